// File: rtl/counter_scheduler_pkg.sv
// counter_scheduler_pkg: shared FSM state encoding and round-robin wrap helper
package counter_scheduler_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
   function automatic int rr_next(input int k, input int n);
      return (k + 1) % n;
   endfunction
endpackage

// File: rtl/sched_count_engine.sv
// sched_count_engine: loadable up-counter that stops at its terminal value
module sched_count_engine #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             clear_i,
   input  logic             enable_i,
   input  logic [WIDTH-1:0] term_i,
   output logic [WIDTH-1:0] count_o,
   output logic             at_term_o
);
   logic [WIDTH-1:0] count_q, count_d;
   assign at_term_o = count_q == term_i;
   assign count_o   = count_q;
   // clear wins over enable; the count saturates at term so it can never wrap
   always_comb count_d = clear_i ? '0 : (enable_i && !at_term_o) ? count_q + 1'b1 : count_q;
   // count register
   always_ff @(posedge clk) count_q <= RST ? '0 : count_d;
endmodule

// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin arbiter sharing one count engine among requesters
module counter_scheduler
   import counter_scheduler_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                   clk,
   input  logic                   RST,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] len,
   output logic [N_REQ-1:0]       gnt,
   output logic [N_REQ-1:0]       done,
   output logic                   busy,
   output logic [WIDTH-1:0]       count,
   output logic [ID_W-1:0]        owner
);
   state_e           state_q, state_d;
   logic [ID_W-1:0]  owner_q, owner_d, ptr_q, ptr_d, pick;
   logic [WIDTH-1:0] term_q, term_d;
   logic             clear, enable, at_term;
   logic [N_REQ-1:0] owner_oh;
   sched_count_engine #(.WIDTH(WIDTH)) u_engine (
      .clk       (clk),
      .RST       (RST),
      .clear_i   (clear),
      .enable_i  (enable),
      .term_i    (term_q),
      .count_o   (count),
      .at_term_o (at_term)
   );
   // first requester at or after the pointer; scanning downward leaves the nearest one
   always_comb begin
      pick = ptr_q;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (req[(int'(ptr_q) + i) % N_REQ]) pick = ID_W'((int'(ptr_q) + i) % N_REQ);
   end
   // next state: grant from IDLE, count or cancel in RUN, release after DONE
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      term_d  = term_q;
      clear   = 1'b0;
      enable  = 1'b0;
      case (state_q)
         IDLE: if (|req) begin
            state_d = RUN;
            owner_d = pick;
            term_d  = len[pick*WIDTH +: WIDTH];
            clear   = 1'b1;
         end
         RUN: if (at_term) state_d = DONE;
         else if (!req[owner_q]) begin
            state_d = IDLE;
            ptr_d   = ID_W'(rr_next(int'(owner_q), N_REQ));
            clear   = 1'b1;
         end else enable = 1'b1;
         DONE: begin
            state_d = IDLE;
            ptr_d   = ID_W'(rr_next(int'(owner_q), N_REQ));
            clear   = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   // state registers
   always_ff @(posedge clk) begin
      state_q <= RST ? IDLE : state_d;
      owner_q <= RST ? '0 : owner_d;
      ptr_q   <= RST ? '0 : ptr_d;
      term_q  <= RST ? '0 : term_d;
   end
   assign owner_oh = N_REQ'(1) << owner_q;
   assign gnt      = (state_q != IDLE) ? owner_oh : '0;
   assign done     = (state_q == DONE) ? owner_oh : '0;
   assign busy     = state_q != IDLE;
   assign owner    = owner_q;
endmodule

// File: tb/tb_counter_scheduler.sv
// tb_counter_scheduler: table, directed and randomized checks of counter_scheduler
module tb_counter_scheduler;
   localparam int NR = 4;
   logic        clk, rst;
   logic [3:0]  req, gnt, done;
   logic [31:0] len;
   logic        busy;
   logic [7:0]  count;
   logic [1:0]  owner;
   int n_chk = 0, n_fail = 0;
   bit use_model = 0;
   bit m_act = 0, m_fin = 0;
   int m_own = 0, m_trm = 0, m_cnt = 0, m_ptr = 0;
   typedef struct {
      logic       r;
      logic [3:0] q, g, d;
      logic       b;
      logic [7:0] c;
      logic [1:0] o;
   } vec_t;
   vec_t tbl[11];

   counter_scheduler #(.WIDTH(8), .N_REQ(4), .ID_W(2)) dut (
      .clk(clk), .RST(rst), .req(req), .len(len), .gnt(gnt),
      .done(done), .busy(busy), .count(count), .owner(owner)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference: one transaction at a time, owner found by a modular scan from the pointer
   task automatic mstep();
      if (rst) begin
         m_act = 0; m_fin = 0; m_own = 0; m_cnt = 0; m_ptr = 0;
      end else if (m_fin) begin
         m_fin = 0; m_act = 0; m_cnt = 0; m_ptr = (m_own + 1) % NR;
      end else if (m_act) begin
         if (m_cnt == m_trm) m_fin = 1;
         else if (!req[m_own]) begin
            m_act = 0; m_cnt = 0; m_ptr = (m_own + 1) % NR;
         end else m_cnt++;
      end else if (req != 0) begin
         for (int i = 0; i < NR; i++)
            if (req[(m_ptr + i) % NR]) begin
               m_own = (m_ptr + i) % NR;
               break;
            end
         m_trm = int'(len[m_own*8 +: 8]);
         m_cnt = 0;
         m_act = 1;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      mstep();
      #1;
      if (use_model) begin
         chk("gnt", 32'(gnt), m_act ? 32'(1 << m_own) : 32'd0);
         chk("done", 32'(done), m_fin ? 32'(1 << m_own) : 32'd0);
         chk("busy", 32'(busy), 32'(m_act));
         chk("count", 32'(count), 32'(m_cnt));
         chk("owner", 32'(owner), 32'(m_own));
      end
   endtask

   task automatic do_reset();
      rst = 1; req = 0;
      cyc(); cyc();
      rst = 0;
   endtask

   initial begin
      int runs, maxc;
      bit got_done;
      int order[$];
      rst = 1; req = 0; len = 32'h0003_0000;
      tbl[0]  = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 8'd0, 2'd0};
      tbl[1]  = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 8'd0, 2'd0};
      tbl[2]  = '{1'b0, 4'hF, 4'h1, 4'h0, 1'b1, 8'd0, 2'd0};
      tbl[3]  = '{1'b0, 4'hF, 4'h1, 4'h1, 1'b1, 8'd0, 2'd0};
      tbl[4]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 8'd0, 2'd0};
      tbl[5]  = '{1'b0, 4'h4, 4'h4, 4'h0, 1'b1, 8'd0, 2'd2};
      tbl[6]  = '{1'b0, 4'h4, 4'h4, 4'h0, 1'b1, 8'd1, 2'd2};
      tbl[7]  = '{1'b0, 4'h4, 4'h4, 4'h0, 1'b1, 8'd2, 2'd2};
      tbl[8]  = '{1'b0, 4'h4, 4'h4, 4'h0, 1'b1, 8'd3, 2'd2};
      tbl[9]  = '{1'b0, 4'h4, 4'h4, 4'h4, 1'b1, 8'd3, 2'd2};
      tbl[10] = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 8'd0, 2'd2};
      for (int i = 0; i < 11; i++) begin
         rst = tbl[i].r; req = tbl[i].q;
         cyc();
         chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].g));
         chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].d));
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].b));
         chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].c));
         chk($sformatf("tbl%0d_owner", i), 32'(owner), 32'(tbl[i].o));
      end
      use_model = 1;

      len = 0;
      do_reset();
      req = 4'hF;
      for (int i = 0; i < 15; i++) begin
         cyc();
         if (done != 0) order.push_back(int'(owner));
      end
      chk("rr_done_count", 32'(order.size()), 32'd5);
      for (int i = 0; i < order.size() && i < 5; i++)
         chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 4));

      len = 32'h0000_00FF;
      do_reset();
      req = 4'h1; runs = 0; maxc = 0; got_done = 0;
      for (int i = 0; i < 300 && !got_done; i++) begin
         cyc();
         if (done != 0) got_done = 1;
         else if (busy) begin
            runs++;
            if (int'(count) > maxc) maxc = int'(count);
         end
      end
      chk("max_runs", 32'(runs), 32'd256);
      chk("max_count", 32'(maxc), 32'd255);
      chk("max_done", 32'(done), 32'h1);

      len = 32'h0000_0A00;
      do_reset();
      req = 4'h1;
      cyc(); cyc();
      req = 4'h2;
      for (int i = 0; i < 30 && !(busy && owner == 2'd1 && count == 8'd5); i++) cyc();
      chk("cancel_reach", 32'(count), 32'd5);
      req = 4'hD;
      cyc();
      chk("cancel_busy", 32'(busy), 32'd0);
      chk("cancel_gnt", 32'(gnt), 32'd0);
      chk("cancel_done", 32'(done), 32'd0);
      req = 4'hF;
      cyc();
      chk("cancel_next_owner", 32'(owner), 32'd2);
      chk("cancel_next_gnt", 32'(gnt), 32'h4);

      len = 32'h0000_0002;
      do_reset();
      req = 4'h1;
      for (int i = 0; i < 10 && !(busy && count == 8'd2 && done == 0); i++) cyc();
      req = 4'h0;
      cyc();
      chk("drop_at_term_done", 32'(done), 32'h1);
      cyc();

      len = 32'h0000_0014;
      do_reset();
      req = 4'h1;
      for (int i = 0; i < 20 && !(busy && count == 8'd7); i++) cyc();
      chk("rst_mid_reach", 32'(count), 32'd7);
      rst = 1;
      cyc();
      chk("rst_mid_gnt", 32'(gnt), 32'd0);
      chk("rst_mid_done", 32'(done), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_count", 32'(count), 32'd0);
      rst = 0;

      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(99) == 0);
         if ($urandom_range(3) == 0) req = 4'($urandom);
         if ($urandom_range(7) == 0)
            for (int j = 0; j < 4; j++) len[j*8 +: 8] = 8'($urandom_range(5));
         cyc();
         chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
